// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher
//
// Round-robin dispatcher for a 1-to-8 demux. It accepts one input stream under
// valid/ready and holds each accepted beat for exactly one output channel.
// Channels are visited in circular order, and channels whose en_mask bit is
// clear are skipped.
//
// Parameters
//   DW  data width of the input beat and the shared output bus
//   CW  width of the delivered-beat counter (wraps modulo 2^CW)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat present
//   in_ready   dispatcher can take a beat this cycle
//   in_data    input beat
//   en_mask    per-channel enable (bit k -> channel k)
//   out_valid  one-hot (or zero) per-channel valid
//   out_ready  per-channel ready; only bit sel is looked at
//   out_data   held beat, meaningful only while out_valid is non-zero
//   sel        channel currently driven (demux select)
//   busy       a beat is held and not yet taken
//   beat_cnt   total beats delivered
module demux_rr_dispatcher #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [7:0]    en_mask,
  output logic [7:0]    out_valid,
  input  logic [7:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    sel,
  output logic          busy,
  output logic [CW-1:0] beat_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [2:0]  ptr;
  logic [2:0]  ptr_eff;
  logic [2:0]  pick;
  logic [2:0]  cand;
  logic        found;
  logic        drain;
  logic        accept;

  assign drain  = (state == HOLD) && out_ready[sel];
  assign accept = in_valid && in_ready;

  // While the held beat leaves this edge, the search starts just past the
  // channel being served, so a back-to-back beat moves on to the next channel.
  assign ptr_eff = drain ? 3'(sel + 3'd1) : ptr;

  // First enabled channel at or after ptr_eff, circularly.
  always_comb begin
    pick  = ptr_eff;
    found = 1'b0;
    cand  = ptr_eff;
    for (int i = 0; i < 8; i++) begin
      cand = 3'(ptr_eff + 3'(i));
      if (!found && en_mask[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = !rst && (en_mask != 8'h00) && ((state == IDLE) || drain);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = HOLD;
      HOLD:    if (drain && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      out_data <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        out_data <= in_data;
        sel      <= pick;
        ptr      <= pick;
      end else if (drain) begin
        ptr <= 3'(sel + 3'd1);
      end
      if (drain) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

  assign out_valid = (state == HOLD) ? (8'b1 << sel) : 8'h00;
  assign busy      = (state == HOLD);

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
module tb_demux_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [7:0]  en_mask;
  logic [7:0]  out_ready;

  logic        in_ready;
  logic [7:0]  out_valid;
  logic [7:0]  out_data;
  logic [2:0]  sel;
  logic        busy;
  logic [15:0] beat_cnt;

  logic        in_ready4;
  logic [7:0]  out_valid4;
  logic [7:0]  out_data4;
  logic [2:0]  sel4;
  logic        busy4;
  logic [3:0]  beat_cnt4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_rr_dispatcher #(.DW(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .en_mask(en_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sel(sel), .busy(busy),
    .beat_cnt(beat_cnt)
  );

  demux_rr_dispatcher #(.DW(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .en_mask(en_mask), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .sel(sel4), .busy(busy4),
    .beat_cnt(beat_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rr_seq [10];
    logic [2:0] sk_seq [5];
    rr_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    sk_seq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};

    // Reset with a valid beat offered
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    en_mask = 8'hFF; out_ready = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'h00);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end

    // Round robin with all channels enabled, back-to-back
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h10 + i);
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("rr_sel", 32'(sel), 32'(rr_seq[i]));
      chk("rr_out_valid", 32'(out_valid), 32'(8'b1 << rr_seq[i]));
      chk("rr_out_data", 32'(out_data), 32'(8'h10 + i));
      chk("rr_beat_cnt", 32'(beat_cnt), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("rr_final_cnt", 32'(beat_cnt), 32'd10);
    chk("rr_idle_valid", 32'(out_valid), 32'h00);

    // Disabled channels skipped (next pointer is 2)
    en_mask = 8'b1010_0100;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h20 + i);
      tick();
      chk("skip_sel", 32'(sel), 32'(sk_seq[i]));
      chk("skip_out_data", 32'(out_data), 32'(8'h20 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("skip_cnt", 32'(beat_cnt), 32'd15);

    // Backpressure on channel 3 while channel 4 is ready
    en_mask = 8'h08; out_ready = 8'h10;
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    in_data = 8'hBB;
    for (int c = 0; c < 4; c++) begin
      chk("bp_out_valid", 32'(out_valid), 32'h08);
      chk("bp_out_data", 32'(out_data), 32'hAA);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_cnt", 32'(beat_cnt), 32'd15);
      tick();
    end
    in_valid = 1'b0; out_ready = 8'h08;
    #1;
    chk("bp_in_ready_drain", 32'(in_ready), 32'd1);
    tick();
    chk("bp_cnt_after", 32'(beat_cnt), 32'd16);
    chk("bp_valid_after", 32'(out_valid), 32'h00);

    // Mask cleared while a beat is held on channel 3; then mask all zero
    out_ready = 8'h00; in_valid = 1'b1; in_data = 8'hC3;
    tick();
    chk("mask_hold_sel", 32'(sel), 32'd3);
    in_valid = 1'b0; en_mask = 8'h00;
    #1;
    chk("mask0_in_ready", 32'(in_ready), 32'd0);
    chk("mask_hold_valid", 32'(out_valid), 32'h08);
    out_ready = 8'h08; in_valid = 1'b1; in_data = 8'hDD;
    #1;
    chk("mask0_in_ready_drain", 32'(in_ready), 32'd0);
    tick();
    chk("mask_drain_cnt", 32'(beat_cnt), 32'd17);
    chk("mask_drain_valid", 32'(out_valid), 32'h00);
    chk("mask_drain_busy", 32'(busy), 32'd0);
    tick();
    chk("mask0_no_accept", 32'(out_valid), 32'h00);
    chk("mask0_cnt", 32'(beat_cnt), 32'd17);

    // Single enabled channel 6, back-to-back
    en_mask = 8'h40; out_ready = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h60 + i);
      #1;
      chk("single_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("single_sel", 32'(sel), 32'd6);
      chk("single_out_data", 32'(out_data), 32'(8'h60 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("single_cnt", 32'(beat_cnt), 32'd20);
    chk("single_cnt4", 32'(beat_cnt4), 32'd4);

    // Reset while holding a beat (next pointer is 7)
    en_mask = 8'hFF; out_ready = 8'h00; in_valid = 1'b1; in_data = 8'h77;
    tick();
    chk("midrst_hold_valid", 32'(out_valid), 32'h80);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'h00);
    chk("midrst_cnt", 32'(beat_cnt), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);

    // 17 drains: the 4-bit counter wraps to 1
    rst = 1'b0; out_ready = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt4", 32'(beat_cnt4), 32'd1);
    chk("wrap_cnt16", 32'(beat_cnt), 32'd17);
    chk("wrap_idle", 32'(out_valid4), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
